aha_sys_reset_sequencer: RTL
============================

# aha_sys_reset_sequencer

Sequences the system-domain reset once the registered combined reset request (SYSRESETREQ / lockup / watchdog) is raised. Optionally quiesces the system bus via a request/acknowledge handshake, holds the system reset low for a fixed number of cycles, then blanks further requests while the system restarts. Also records the reset cause for software. It sits directly downstream of the reset-request combiner in the platform controller, in the always-on domain.

## Interface
- HOLD_CYCLES, 16, cycles SYSRESETn is held low per sequence (≥1)
- BLANK_CYCLES, 8, cycles after release during which requests are ignored (≥1)
- QTIMEOUT_CYCLES, 256, maximum wait for quiesce acknowledge (≥1)
- CLK  in  1  always-on clock
- RESETn  in  1  asynchronous active-low power-on reset
- SYSRESETREQ_COMBINED  in  1  registered level reset request
- CAUSE_IN  in  3  {wdog, lockup, sysresetreq} raw flags, valid with request
- CAUSE_CLR  in  1  single-cycle pulse, clears RESET_CAUSE
- SYS_QACK  in  1  quiesce acknowledge from bus fabric (level)
- SYS_QREQ  out  1  quiesce request, registered
- SYSRESETn  out  1  system reset, active-low, registered
- BUSY  out  1  high in any state other than IDLE
- RESET_CAUSE  out  4  sticky {qtimeout, wdog, lockup, sysresetreq}

Clock and reset are fixed: single clock CLK; RESETn is asynchronous, active-low.

## Operation
- FSM states are IDLE, QUIESCE, ASSERT and BLANK. A single down-counter is shared between QUIESCE, ASSERT and BLANK.
- **Reset:** state=ASSERT, counter=HOLD_CYCLES-1, SYSRESETn=0, SYS_QREQ=0, BUSY=1, RESET_CAUSE=0. Power-on therefore holds the system in reset for HOLD_CYCLES cycles after RESETn deasserts.
- **IDLE:** if SYSRESETREQ_COMBINED=1, the block ORs CAUSE_IN into RESET_CAUSE[2:0] and moves to QUIESCE (counter=QTIMEOUT_CYCLES-1, SYS_QREQ←1).
- **QUIESCE:**
  - If SYS_QACK=1: go to ASSERT (counter=HOLD_CYCLES-1, SYSRESETn←0).
  - Otherwise, if counter==0: set RESET_CAUSE[3] and go to ASSERT anyway.
  - Otherwise: decrement the counter.
- **ASSERT:** SYSRESETn=0. When counter==0, go to BLANK (counter=BLANK_CYCLES-1), with SYSRESETn←1 and SYS_QREQ←0. Otherwise decrement.
- **BLANK:** requests are ignored and not queued. When counter==0, go to IDLE. A request still high in IDLE starts a new sequence.
- **CAUSE_CLR:** clears RESET_CAUSE in any state. If capture happens in the same cycle, the result is cleared-then-ORed, so capture wins.
- **Counter width:** $clog2(max(HOLD_CYCLES,BLANK_CYCLES,QTIMEOUT_CYCLES)). The counter never wraps; each state loads its value before the counter can underflow.
- **SYS_QACK outside QUIESCE:** ignored.
- **RESETn asserted mid-sequence:** immediate return to the reset values above, regardless of state.

## Timing
- Request high at edge N:
  - SYS_QREQ=1 and BUSY=1 after edge N.
  - With SYS_QACK already high, ASSERT is entered at edge N+1, so SYSRESETn=0 after N+1.
- SYSRESETn is low for exactly HOLD_CYCLES cycles.
- Blanking lasts BLANK_CYCLES cycles; BUSY falls with entry to IDLE.
- Timeout path: QUIESCE lasts QTIMEOUT_CYCLES cycles when SYS_QACK stays low.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **With `AHA_RST_SEQ_QUIESCE_EN` defined:** behaviour is as above.
- **Without it:**
  - The QUIESCE state is absent; IDLE goes directly to ASSERT (SYSRESETn=0 after edge N).
  - SYS_QREQ is tied 0, SYS_QACK is unused, and RESET_CAUSE[3] is always 0.

## Structure
- A shared package holds:
  - the state enum (IDLE, QUIESCE, ASSERT, BLANK);
  - the cause bit-index constants (CAUSE_SYSREQ=0, CAUSE_LOCKUP=1, CAUSE_WDOG=2, CAUSE_QTMO=3).
- One sub-module is natural: aha_rst_seq_counter, a loadable down-counter with a zero flag.

## Test plan
- **Power-on:** RESETn low 5 cycles, then high → SYSRESETn low 16 cycles after release, then BLANK 8 cycles, then IDLE (BUSY=0).
- **Quiesce path:** request with CAUSE_IN=3'b100, SYS_QACK high 3 cycles after SYS_QREQ → SYSRESETn low 16 cycles, RESET_CAUSE=4'b0100.
- **Timeout:** QTIMEOUT_CYCLES=4, SYS_QACK held 0 → ASSERT after 4 QUIESCE cycles, RESET_CAUSE[3]=1.
- **Held request:** request held high through the whole sequence → no action during BLANK, second sequence starts on IDLE entry.
- **Clear/capture:** CAUSE_CLR in the same cycle as capture with CAUSE_IN=3'b010 → RESET_CAUSE=4'b0010.
- **Async reset mid-sequence:** RESETn pulsed low mid-ASSERT → immediate reset values, RESET_CAUSE=0, fresh 16-cycle hold.

Source files
------------

// File: rtl/aha_sys_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// aha_sys_reset_sequencer_pkg
//
// Shared definitions for the system reset sequencer:
//   - seq_state_t  : sequencer FSM states (IDLE, QUIESCE, ASSERT, BLANK)
//   - CAUSE_*      : bit positions inside the sticky RESET_CAUSE register
//   - cnt_width()  : width of the shared down-counter for a given set of
//                    cycle counts (never narrower than one bit)
// ---------------------------------------------------------------------------
package aha_sys_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUIESCE = 2'd1,
    ASSERT  = 2'd2,
    BLANK   = 2'd3
  } seq_state_t;

  localparam int CAUSE_SYSREQ = 0;
  localparam int CAUSE_LOCKUP = 1;
  localparam int CAUSE_WDOG   = 2;
  localparam int CAUSE_QTMO   = 3;

  // The counter only ever holds "cycles - 1", so clog2 of the largest cycle
  // count is enough. A degenerate all-ones configuration still needs one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/aha_sys_reset_sequencer_counter.sv
// ---------------------------------------------------------------------------
// aha_rst_seq_counter
//
// Loadable down-counter with a zero flag, shared by every timed state of the
// reset sequencer. Decrement saturates at zero so the count can never wrap.
//
// Ports:
//   CLK         in  clock
//   RESETn      in  asynchronous active-low reset (loads RESET_VALUE)
//   load        in  load load_value this cycle (takes priority over dec)
//   load_value  in  value to load
//   dec         in  decrement by one when non-zero
//   zero        out count is zero
// ---------------------------------------------------------------------------
module aha_rst_seq_counter #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over decrement; decrement stops at zero so the owning state
  // always reloads before anything could underflow.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/aha_sys_reset_sequencer.sv
// ---------------------------------------------------------------------------
// aha_sys_reset_sequencer
//
// Always-on sequencer for the system-domain reset. On a registered combined
// reset request it (optionally) quiesces the system bus, holds SYSRESETn low
// for HOLD_CYCLES, then ignores requests for BLANK_CYCLES while the system
// restarts. The cause of each reset is accumulated in a sticky register.
//
// Build option:
//   AHA_RST_SEQ_QUIESCE_EN  defined   : QUIESCE handshake via SYS_QREQ/SYS_QACK
//                                       with a QTIMEOUT_CYCLES timeout
//                           undefined : IDLE goes straight to ASSERT,
//                                       SYS_QREQ tied low, SYS_QACK unused,
//                                       RESET_CAUSE[3] always 0
//
// Ports:
//   CLK                   in   always-on clock
//   RESETn                in   asynchronous active-low power-on reset
//   SYSRESETREQ_COMBINED  in   registered level reset request
//   CAUSE_IN[2:0]         in   {wdog, lockup, sysresetreq} flags
//   CAUSE_CLR             in   pulse, clears RESET_CAUSE
//   SYS_QACK              in   quiesce acknowledge (level)
//   SYS_QREQ              out  quiesce request (registered)
//   SYSRESETn             out  system reset, active-low (registered)
//   BUSY                  out  sequencer not in IDLE (registered)
//   RESET_CAUSE[3:0]      out  sticky {qtimeout, wdog, lockup, sysresetreq}
// ---------------------------------------------------------------------------
module aha_sys_reset_sequencer
  import aha_sys_reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES     = 16,
  parameter int BLANK_CYCLES    = 8,
  parameter int QTIMEOUT_CYCLES = 256
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       SYSRESETREQ_COMBINED,
  input  logic [2:0] CAUSE_IN,
  input  logic       CAUSE_CLR,
  input  logic       SYS_QACK,
  output logic       SYS_QREQ,
  output logic       SYSRESETn,
  output logic       BUSY,
  output logic [3:0] RESET_CAUSE
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, BLANK_CYCLES, QTIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
`ifdef AHA_RST_SEQ_QUIESCE_EN
  localparam logic [CNT_W-1:0] QTMO_LOAD  = CNT_W'(QTIMEOUT_CYCLES - 1);
`endif

  seq_state_t       state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [3:0]       cause_next;

  // Power-on lands in ASSERT with the hold count preloaded, so the counter
  // resets to the same value the ASSERT state would load.
  aha_rst_seq_counter #(
    .WIDTH       (CNT_W),
    .RESET_VALUE (HOLD_LOAD)
  ) u_counter (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // Counter control: every transition into a timed state loads that state's
  // length minus one; otherwise the current timed state counts down.
  always_comb begin
    cnt_load       = 1'b0;
    cnt_load_value = HOLD_LOAD;
    cnt_dec        = 1'b0;
    case (state)
      IDLE: begin
        if (SYSRESETREQ_COMBINED) begin
          cnt_load = 1'b1;
`ifdef AHA_RST_SEQ_QUIESCE_EN
          cnt_load_value = QTMO_LOAD;
`else
          cnt_load_value = HOLD_LOAD;
`endif
        end
      end
      QUIESCE: begin
`ifdef AHA_RST_SEQ_QUIESCE_EN
        if (SYS_QACK || cnt_zero) begin
          cnt_load       = 1'b1;
          cnt_load_value = HOLD_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      ASSERT: begin
        if (cnt_zero) begin
          cnt_load       = 1'b1;
          cnt_load_value = BLANK_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      BLANK: begin
        cnt_dec = !cnt_zero;
      end
      default: begin
        cnt_load       = 1'b0;
      end
    endcase
  end

  // Sticky cause: a clear and a capture in the same cycle resolve as
  // clear-then-OR, so the freshly captured cause survives.
  always_comb begin
    cause_next = CAUSE_CLR ? 4'b0000 : RESET_CAUSE;
    if ((state == IDLE) && SYSRESETREQ_COMBINED) begin
      cause_next[CAUSE_SYSREQ] = cause_next[CAUSE_SYSREQ] | CAUSE_IN[CAUSE_SYSREQ];
      cause_next[CAUSE_LOCKUP] = cause_next[CAUSE_LOCKUP] | CAUSE_IN[CAUSE_LOCKUP];
      cause_next[CAUSE_WDOG]   = cause_next[CAUSE_WDOG]   | CAUSE_IN[CAUSE_WDOG];
    end
`ifdef AHA_RST_SEQ_QUIESCE_EN
    if ((state == QUIESCE) && !SYS_QACK && cnt_zero) begin
      cause_next[CAUSE_QTMO] = 1'b1;
    end
`endif
  end

  // Main sequencer FSM. All outputs are registered here so nothing on the
  // input side can reach an output combinationally. Requests arriving in
  // BLANK are simply not looked at; a request still high in IDLE restarts.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= ASSERT;
      SYSRESETn   <= 1'b0;
      BUSY        <= 1'b1;
      RESET_CAUSE <= 4'b0000;
`ifdef AHA_RST_SEQ_QUIESCE_EN
      SYS_QREQ    <= 1'b0;
`endif
    end else begin
      RESET_CAUSE <= cause_next;
      case (state)
        IDLE: begin
          if (SYSRESETREQ_COMBINED) begin
            BUSY <= 1'b1;
`ifdef AHA_RST_SEQ_QUIESCE_EN
            state    <= QUIESCE;
            SYS_QREQ <= 1'b1;
`else
            state     <= ASSERT;
            SYSRESETn <= 1'b0;
`endif
          end
        end
        QUIESCE: begin
`ifdef AHA_RST_SEQ_QUIESCE_EN
          if (SYS_QACK || cnt_zero) begin
            state     <= ASSERT;
            SYSRESETn <= 1'b0;
          end
`else
          state <= IDLE;
          BUSY  <= 1'b0;
`endif
        end
        ASSERT: begin
          if (cnt_zero) begin
            state     <= BLANK;
            SYSRESETn <= 1'b1;
`ifdef AHA_RST_SEQ_QUIESCE_EN
            SYS_QREQ  <= 1'b0;
`endif
          end
        end
        BLANK: begin
          if (cnt_zero) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          BUSY      <= 1'b0;
          SYSRESETn <= 1'b1;
        end
      endcase
    end
  end

`ifndef AHA_RST_SEQ_QUIESCE_EN
  // Without the quiesce handshake the request is permanently idle and the
  // acknowledge is deliberately left unconnected.
  logic unused_qack;
  assign unused_qack = SYS_QACK;
  assign SYS_QREQ    = 1'b0;
`endif

endmodule
